// File: rtl/arcade_loader_pkg.sv
// arcade_loader_pkg: shared loader state, ioctl address width and port window type
package arcade_loader_pkg;
  localparam int IOCTL_AW = 25;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} loader_state_e;
  typedef struct packed {
    logic [IOCTL_AW-1:0] base;
    logic [IOCTL_AW-1:0] size;
  } region_t;
endpackage

// File: rtl/rom_port_ch.sv
// rom_port_ch: one sdram write port with window decode, remap, toggle handshake and overrun flag
module rom_port_ch
  import arcade_loader_pkg::*;
#(
  parameter int PORT_AW = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic [IOCTL_AW-1:0] addr,
  input  logic [7:0]          dout,
  input  region_t             region,
  input  logic                ack,
  output logic                req,
  output logic [PORT_AW-1:0]  a,
  output logic [1:0]          ds,
  output logic [15:0]         d,
  output logic                overrun
);
  logic [IOCTL_AW:0] lim;
  logic [IOCTL_AW-1:0] off;
  logic hit;
  // widened limit so base+size never wraps
  assign lim = {1'b0, region.base} + {1'b0, region.size};
  assign off = addr - region.base;
  assign hit = addr >= region.base && {1'b0, addr} < lim;
  always_ff @(posedge clk) begin
    if (rst) begin
      req <= 1'b0;
      a <= '0;
      ds <= '0;
      d <= '0;
      overrun <= 1'b0;
    end else if (accept && hit) begin
      if (req == ack) begin
        a <= PORT_AW'(off >> 1);
        ds <= {addr[0], ~addr[0]};
        d <= {dout, dout};
        req <= ~req;
      end else begin
        overrun <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/arcade_rom_loader.sv
// arcade_rom_loader: routes ioctl rom bytes to sdram write ports and sequences core reset
module arcade_rom_loader
  import arcade_loader_pkg::*;
#(
  parameter int                              NUM_PORTS   = 2,
  parameter int                              PORT_AW     = 23,
  parameter logic [7:0]                      ROM_INDEX   = 8'h00,
  parameter logic [NUM_PORTS*IOCTL_AW-1:0]   REGION_BASE = {25'h0e000, 25'h0},
  parameter logic [NUM_PORTS*IOCTL_AW-1:0]   REGION_SIZE = {25'h20000, 25'h0e000},
  parameter logic [15:0]                     HOLD_CYCLES = 16'hffff
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         user_reset,
  input  logic                         ioctl_downl,
  input  logic [7:0]                   ioctl_index,
  input  logic                         ioctl_wr,
  input  logic [IOCTL_AW-1:0]          ioctl_addr,
  input  logic [7:0]                   ioctl_dout,
  output logic [NUM_PORTS-1:0]         port_req,
  input  logic [NUM_PORTS-1:0]         port_ack,
  output logic [NUM_PORTS*PORT_AW-1:0] port_a,
  output logic [NUM_PORTS*2-1:0]       port_ds,
  output logic [NUM_PORTS*16-1:0]      port_d,
  output logic                         rom_loaded,
  output logic                         core_reset,
  output logic [NUM_PORTS-1:0]         overrun,
  output logic [IOCTL_AW-1:0]          byte_count
);
  loader_state_e state;
  logic wr_q, rom_hit, accept;
  logic [15:0] cnt;
  assign rom_hit = ioctl_index == ROM_INDEX;
  // LOAD term keeps a write that coincides with the downl fall
  assign accept = ioctl_wr & ~wr_q & ((ioctl_downl & rom_hit) | state == LOAD);
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ch
    region_t rg;
    assign rg = '{base: REGION_BASE[p*IOCTL_AW +: IOCTL_AW], size: REGION_SIZE[p*IOCTL_AW +: IOCTL_AW]};
    rom_port_ch #(.PORT_AW(PORT_AW)) u_ch (
      .clk(clk_sys), .rst(reset), .accept(accept), .addr(ioctl_addr), .dout(ioctl_dout),
      .region(rg), .ack(port_ack[p]), .req(port_req[p]), .a(port_a[p*PORT_AW +: PORT_AW]),
      .ds(port_ds[2*p +: 2]), .d(port_d[16*p +: 16]), .overrun(overrun[p])
    );
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      rom_loaded <= 1'b0;
      byte_count <= '0;
      wr_q <= 1'b0;
      cnt <= HOLD_CYCLES;
      core_reset <= 1'b1;
    end else begin
      wr_q <= ioctl_wr;
      cnt <= (user_reset | ~rom_loaded) ? HOLD_CYCLES : cnt - 16'(cnt != 16'd0);
      core_reset <= user_reset | ~rom_loaded | cnt == 16'd1;
      case (state)
        IDLE, DONE: if (ioctl_downl & rom_hit) begin
          state <= LOAD;
          rom_loaded <= 1'b0;
          byte_count <= IOCTL_AW'(accept);
        end
        LOAD: begin
          byte_count <= byte_count + IOCTL_AW'(accept);
          if (!ioctl_downl) state <= DRAIN;
        end
        DRAIN: if (port_req == port_ack) begin
          state <= DONE;
          rom_loaded <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
